// File: rtl/nibble_store_pkg.sv
// Shared constants and types for the video nibble store and its readers.
// Holds the store geometry, port-B read latency and the reader FSM states.
package nibble_store_pkg;

    localparam int NIB_ADDR_W     = 15;
    localparam int NIB_DATA_W     = 4;
    localparam int NIB_MEM_WORDS  = 20480;
    localparam int NIB_RD_LATENCY = 2;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } reader_state_t;

endpackage

// File: rtl/nibble_fifo.sv
// Synchronous show-ahead FIFO with occupancy count and flush.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   i_flush      : empties the FIFO at the next edge (wins over push)
//   i_push/i_data: write one entry
//   i_pop        : remove head entry (ignored when empty)
//   o_data       : head entry, valid whenever o_empty is low
//   o_empty      : no entries held
//   o_count      : number of entries held
import nibble_store_pkg::*;

module nibble_fifo #(
    parameter int WIDTH = NIB_DATA_W + 1,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           i_flush,
    input  logic                           i_push,
    input  logic [WIDTH-1:0]               i_data,
    input  logic                           i_pop,
    output logic [WIDTH-1:0]               o_data,
    output logic                           o_empty,
    output logic [$clog2(DEPTH+1)-1:0]     o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !w_empty;

    // Storage needs no reset: only entries below r_count are ever visible.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({i_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The writer's credit accounting must never let a push land on a
    // full FIFO unless an entry leaves in the same cycle.
    always_ff @(posedge clk) begin
        a_no_overflow: assert (reset || i_flush || !(i_push && w_full && !w_pop));
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/nibble_frame_reader.sv
// Read-side frame engine for the dual-port nibble store (port B).
// Sweeps BASE_ADDR..BASE_ADDR+FRAME_LEN-1 on start and streams the nibbles
// out as valid/ready with a last marker, using credit-limited prefetch.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start, abort        : one-cycle frame start / cancel pulses
//   busy, done          : frame in progress / completion pulse
//   mem_adb, mem_ceb    : port-B address and read issue
//   mem_oceb            : port-B output register enable
//   mem_doutb           : port-B read data (RD_LATENCY cycles after issue)
//   pix_data/valid/last : output stream towards the pixel serializer
//   pix_ready           : downstream accept
module nibble_frame_reader
    import nibble_store_pkg::*;
#(
    parameter int ADDR_W     = NIB_ADDR_W,
    parameter int DATA_W     = NIB_DATA_W,
    parameter int BASE_ADDR  = 0,
    parameter int FRAME_LEN  = NIB_MEM_WORDS,
    parameter int RD_LATENCY = NIB_RD_LATENCY,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] mem_adb,
    output logic              mem_ceb,
    output logic              mem_oceb,
    input  logic [DATA_W-1:0] mem_doutb,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    input  logic              pix_ready,
    output logic              pix_last
);

    localparam int CTR_W = ADDR_W + 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int IFL_W = $clog2(RD_LATENCY + 1);
    localparam int SUM_W = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;

    localparam logic [CTR_W-1:0] LAST_IDX = CTR_W'(FRAME_LEN - 1);
    localparam logic [CTR_W-1:0] LEN_C    = CTR_W'(FRAME_LEN);

    generate
        if (BASE_ADDR + FRAME_LEN > NIB_MEM_WORDS) begin : g_bad_window
            $error("nibble_frame_reader: BASE_ADDR+FRAME_LEN exceeds store");
        end
        if (FRAME_LEN < 1) begin : g_bad_len
            $error("nibble_frame_reader: FRAME_LEN must be at least 1");
        end
        if (RD_LATENCY < 1) begin : g_bad_lat
            $error("nibble_frame_reader: RD_LATENCY must be at least 1");
        end
        if (FIFO_DEPTH < RD_LATENCY + 1) begin : g_bad_depth
            $error("nibble_frame_reader: FIFO_DEPTH below RD_LATENCY+1");
        end
        if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_pow2
            $error("nibble_frame_reader: FIFO_DEPTH must be a power of two");
        end
    endgenerate

    reader_state_t r_state;

    logic [CTR_W-1:0]      r_issue_ctr;
    logic [CTR_W-1:0]      r_recv_ctr;
    logic [RD_LATENCY-1:0] r_inflight;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_oceb;

    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_empty;
    logic [DATA_W:0]   w_fifo_head;
    logic [IFL_W-1:0]  w_inflight_cnt;
    logic [SUM_W-1:0]  w_used;
    logic              w_credit_ok;
    logic              w_issue;
    logic              w_abort;
    logic              w_push;
    logic              w_push_last;
    logic              w_pop;
    logic              w_drained;

    always_comb begin
        w_inflight_cnt = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            w_inflight_cnt = w_inflight_cnt + IFL_W'(r_inflight[i]);
        end
    end

    // Credit check uses only registered occupancy; a pop in the same
    // cycle is not credited, so pix_ready never reaches mem_ceb.
    assign w_used      = SUM_W'(w_fifo_count) + SUM_W'(w_inflight_cnt);
    assign w_credit_ok = (w_used < SUM_W'(FIFO_DEPTH));

    assign w_issue     = (r_state == FETCH) && w_credit_ok;
    assign w_abort     = abort && (r_state != IDLE);
    assign w_push      = r_inflight[RD_LATENCY-1];
    assign w_push_last = (r_recv_ctr == LAST_IDX);
    assign w_pop       = !w_fifo_empty && pix_ready;
    assign w_drained   = w_fifo_empty && (r_inflight == '0) &&
                         (r_recv_ctr == LEN_C);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_issue_ctr <= '0;
            r_recv_ctr  <= '0;
            r_inflight  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_oceb      <= 1'b0;
        end else begin
            r_oceb     <= 1'b1;
            r_done     <= 1'b0;
            r_inflight <= (r_inflight << 1) | RD_LATENCY'(w_issue);

            if (w_issue) begin
                r_issue_ctr <= r_issue_ctr + 1'b1;
            end
            if (w_push) begin
                r_recv_ctr <= r_recv_ctr + 1'b1;
            end

            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state     <= FETCH;
                        r_issue_ctr <= '0;
                        r_recv_ctr  <= '0;
                        r_busy      <= 1'b1;
                    end
                end
                FETCH: begin
                    if (w_issue && (r_issue_ctr == LAST_IDX)) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (w_drained) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Clearing the tracker makes late port-B data harmless.
            if (w_abort) begin
                r_state    <= IDLE;
                r_busy     <= 1'b0;
                r_done     <= 1'b0;
                r_inflight <= '0;
            end
        end
    end

    nibble_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (w_abort),
        .i_push  (w_push),
        .i_data  ({w_push_last, mem_doutb}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_head),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Issue signals derive only from registers, so they are clean for the
    // whole cycle; the address is held at zero outside FETCH.
    assign mem_ceb  = w_issue;
    assign mem_adb  = (r_state == FETCH) ?
                      ADDR_W'(BASE_ADDR) + r_issue_ctr[ADDR_W-1:0] : '0;
    assign mem_oceb = r_oceb;

    assign pix_valid = !w_fifo_empty;
    assign pix_data  = pix_valid ? w_fifo_head[DATA_W-1:0] : '0;
    assign pix_last  = pix_valid && w_fifo_head[DATA_W];

    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_nibble_frame_reader.sv
// Self-checking bench for nibble_frame_reader with a port-B store model.
// Three readers share one store image: full frame, bank edge, short frame.
module tb_nibble_frame_reader;

    logic clk = 1'b0;
    logic reset;

    logic        start_r [3];
    logic        abort_r [3];
    logic        ready_r [3];
    logic        busy_w  [3];
    logic        done_w  [3];
    logic [14:0] adb_w   [3];
    logic        ceb_w   [3];
    logic        oceb_w  [3];
    logic [3:0]  pdata_w [3];
    logic        valid_w [3];
    logic        last_w  [3];

    logic [3:0] mem [20480];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int GB = (g == 0) ? 0 : (g == 1) ? 16380 : 100;
        localparam int GL = (g == 0) ? 20480 : (g == 1) ? 8 : 64;
        logic [3:0] s1_q;
        logic [3:0] dout_q;

        nibble_frame_reader #(
            .ADDR_W(15), .DATA_W(4), .BASE_ADDR(GB), .FRAME_LEN(GL),
            .RD_LATENCY(2), .FIFO_DEPTH(4)
        ) u_dut (
            .clk(clk), .reset(reset),
            .start(start_r[g]), .abort(abort_r[g]),
            .busy(busy_w[g]), .done(done_w[g]),
            .mem_adb(adb_w[g]), .mem_ceb(ceb_w[g]), .mem_oceb(oceb_w[g]),
            .mem_doutb(dout_q),
            .pix_data(pdata_w[g]), .pix_valid(valid_w[g]),
            .pix_ready(ready_r[g]), .pix_last(last_w[g])
        );

        // Two-stage registered read: array stage on ceb, output stage on oceb.
        always @(posedge clk) begin
            if (ceb_w[g]) s1_q <= (adb_w[g] < 15'd20480) ? mem[adb_w[g]] : 4'h0;
            if (oceb_w[g]) dout_q <= s1_q;
        end
    end

    int checks = 0;
    int failures = 0;

    // Reference model of the active frame.
    int k = 0;
    int base_a = 0;
    int len_a = 0;
    logic [3:0] exp_q [$];
    int pos = 0, issued = 0, done_cnt = 0, last_cnt = 0;
    int t = 0, first_v = -1, gaps = 0;
    bit active = 0, stall_prev = 0;
    logic [3:0] prev_d = '0;
    logic prev_l = 1'b0;

    function automatic int base_of(input int kk);
        return (kk == 0) ? 0 : (kk == 1) ? 16380 : 100;
    endfunction

    function automatic int len_of(input int kk);
        return (kk == 0) ? 20480 : (kk == 1) ? 8 : 64;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, check outputs, account transfer.
    task automatic step(input bit rdy, input bit st, input bit ab, input bit rs);
        ready_r[k] = rdy;
        start_r[k] = st;
        abort_r[k] = ab;
        reset = rs;
        if (ceb_w[k]) begin
            if (active) begin
                chk("adb", 32'(adb_w[k]), 32'(base_a + issued));
                chk("credit", 32'((issued - pos) < 4), 32'd1);
                issued++;
            end else begin
                chk("ceb_idle", 32'(ceb_w[k]), 32'd0);
            end
        end
        if (valid_w[k]) begin
            if (!active) chk("valid_idle", 32'(valid_w[k]), 32'd0);
            if (first_v < 0) first_v = t;
            if (stall_prev) begin
                chk("hold_data", 32'(pdata_w[k]), 32'(prev_d));
                chk("hold_last", 32'(last_w[k]), 32'(prev_l));
            end
            if (rdy) begin
                if (pos < exp_q.size()) begin
                    chk("data", 32'(pdata_w[k]), 32'(exp_q[pos]));
                    chk("last", 32'(last_w[k]), 32'(pos == len_a - 1));
                    if (last_w[k]) last_cnt++;
                    pos++;
                end else begin
                    chk("overrun", 32'(pos), 32'(exp_q.size()));
                end
            end
        end else if (active && first_v >= 0 && pos < len_a) begin
            gaps++;
        end
        stall_prev = valid_w[k] && !rdy;
        prev_d = pdata_w[k];
        prev_l = last_w[k];
        if (done_w[k]) begin
            done_cnt++;
            chk("done_at_end", 32'(pos), 32'(len_a));
            chk("busy_at_done", 32'(busy_w[k]), 32'd0);
            active = 0;
        end
        t++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic begin_frame(input int kk, input bit rdy, input bit ab);
        k = kk;
        base_a = base_of(kk);
        len_a = len_of(kk);
        exp_q.delete();
        for (int i = 0; i < len_a; i++) exp_q.push_back(mem[base_a + i]);
        pos = 0; issued = 0; done_cnt = 0; last_cnt = 0;
        t = 0; first_v = -1; gaps = 0; stall_prev = 0;
        active = 1;
        step(rdy, 1'b1, ab, 1'b0);
    endtask

    task automatic finish_frame(input string tag, input int duty, input int budget, input bit timing);
        int n = 0;
        while (done_cnt == 0 && n < budget) begin
            step($urandom_range(0, 99) < duty, 1'b0, 1'b0, 1'b0);
            n++;
        end
        chk({tag, "_done"}, 32'(done_cnt), 32'd1);
        chk({tag, "_count"}, 32'(pos), 32'(len_a));
        chk({tag, "_lastcnt"}, 32'(last_cnt), 32'd1);
        chk({tag, "_issued"}, 32'(issued), 32'(len_a));
        if (timing) begin
            chk({tag, "_first_valid_edges"}, 32'(first_v - 1), 32'd3);
            chk({tag, "_gaps"}, 32'(gaps), 32'd0);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
        chk({tag, "_busy_after"}, 32'(busy_w[k]), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag, input int g);
        chk({tag, "_busy"}, 32'(busy_w[g]), 32'd0);
        chk({tag, "_done"}, 32'(done_w[g]), 32'd0);
        chk({tag, "_adb"}, 32'(adb_w[g]), 32'd0);
        chk({tag, "_ceb"}, 32'(ceb_w[g]), 32'd0);
        chk({tag, "_valid"}, 32'(valid_w[g]), 32'd0);
        chk({tag, "_last"}, 32'(last_w[g]), 32'd0);
        chk({tag, "_data"}, 32'(pdata_w[g]), 32'd0);
    endtask

    initial begin
        logic [14:0] a;
        reset = 1'b1;
        for (int g = 0; g < 3; g++) begin
            start_r[g] = 1'b0;
            abort_r[g] = 1'b0;
            ready_r[g] = 1'b0;
        end
        for (int i = 0; i < 20480; i++) begin
            a = 15'(i);
            mem[i] = a[3:0] ^ a[14:11];
        end
        @(negedge clk);

        // Reset state.
        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int g = 0; g < 3; g++) chk_reset_outputs("rst", g);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        for (int g = 0; g < 3; g++) chk("oceb_after_reset", 32'(oceb_w[g]), 32'd1);

        // Full 20480-nibble frame, ready held high.
        begin_frame(0, 1'b1, 1'b0);
        finish_frame("full", 100, 20600, 1'b1);

        // Window straddling address 16384.
        begin_frame(1, 1'b1, 1'b0);
        finish_frame("bank", 100, 100, 1'b1);

        // Random store contents for the remaining frames.
        for (int i = 0; i < 20480; i++) mem[i] = 4'($urandom);

        // Backpressure at roughly 30% ready.
        begin_frame(2, 1'b0, 1'b0);
        finish_frame("bp30", 30, 3000, 1'b0);

        // Long stall straight after start: only four reads may issue.
        begin_frame(2, 1'b0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_issued_10", 32'(issued), 32'd4);
        repeat (39) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("stall_issued_50", 32'(issued), 32'd4);
        chk("stall_no_accept", 32'(pos), 32'd0);
        finish_frame("stall", 100, 200, 1'b0);

        // Abort with reads in flight, then restart with start+abort together.
        begin_frame(2, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        active = 0;
        chk("abort_valid", 32'(valid_w[2]), 32'd0);
        chk("abort_busy", 32'(busy_w[2]), 32'd0);
        chk("abort_ceb", 32'(ceb_w[2]), 32'd0);
        chk("abort_done", 32'(done_w[2]), 32'd0);
        done_cnt = 0;
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("abort_no_done", 32'(done_cnt), 32'd0);
        begin_frame(2, 1'b1, 1'b1);
        finish_frame("restart", 100, 200, 1'b1);

        // start while busy is ignored; reset mid-frame cleans everything.
        begin_frame(2, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("busy_start_busy", 32'(busy_w[2]), 32'd1);
        repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        active = 0;
        chk_reset_outputs("midrst", 2);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        begin_frame(2, 1'b1, 1'b0);
        finish_frame("postrst", 100, 200, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
